// File: rtl/wb_if.sv
// wb_if: memory-stage to writeback-stage instruction handoff bus.
interface wb_if #(parameter int XLEN = 32, parameter int RA_W = 5);
  logic            in_valid;
  logic            in_ready;
  logic            in_flush;
  logic [RA_W-1:0] in_rd;
  logic            in_rd_we;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_load_data;
  logic [2:0]      in_funct3;
  modport master (output in_valid, in_flush, in_rd, in_rd_we, in_wb_sel, in_alu_result,
                  in_pc, in_load_data, in_funct3, input in_ready);
  modport slave  (input in_valid, in_flush, in_rd, in_rd_we, in_wb_sel, in_alu_result,
                  in_pc, in_load_data, in_funct3, output in_ready);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; holds one retiring instruction, selects its result and
// drives the register-file write port, forwarding copy, fault report and instret.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_stall,
  wb_if.slave              up,
  output logic             rf_write_en,
  output logic [RA_W-1:0]  rf_write_reg,
  output logic [XLEN-1:0]  rf_write_data,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] instret
);
  logic            valid, rd_we;
  logic [RA_W-1:0] rd;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] alu, pc, ld;
  logic [2:0]      f3;
  logic [1:0]      lo, cause;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [XLEN-1:0] ld_val, result;
  logic            fault;
  assign up.in_ready = !wb_stall;
  assign lo   = alu[1:0];
  assign bsel = ld[{lo, 3'b000} +: 8];
  assign hsel = ld[{lo[1], 4'b0000} +: 16];
  always_comb begin
    cause  = (f3 == 3'b000 || f3 == 3'b100) ? 2'b00 :
             (f3 == 3'b001 || f3 == 3'b101) ? {1'b0, lo[0]} :
             (f3 == 3'b010)                 ? {1'b0, |lo} : 2'b10;
    ld_val = f3[1] ? ld :
             f3[0] ? {{(XLEN-16){hsel[15] & ~f3[2]}}, hsel} :
                     {{(XLEN-8){bsel[7] & ~f3[2]}}, bsel};
    result = (wb_sel == 2'b01) ? ld_val :
             (wb_sel == 2'b10) ? pc + {{(XLEN-3){1'b0}}, 3'd4} : alu;
  end
  assign fault         = (wb_sel == 2'b01) && |cause;
  assign rf_write_en   = valid && rd_we && |rd && !fault && !wb_stall;
  assign rf_write_reg  = valid ? rd : '0;
  assign rf_write_data = valid ? result : '0;
  assign fwd_valid     = rf_write_en;
  assign fwd_rd        = rf_write_reg;
  assign fwd_data      = rf_write_data;
  assign exc_valid     = valid && fault && !wb_stall;
  assign exc_cause     = exc_valid ? cause : 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      rd      <= '0;
      rd_we   <= 1'b0;
      wb_sel  <= 2'b00;
      alu     <= '0;
      pc      <= '0;
      ld      <= '0;
      f3      <= 3'b000;
      instret <= '0;
    end else if (!wb_stall) begin
      // a held entry always completes here, even when the offer is flushed
      if (valid && !fault) instret <= instret + CNT_W'(1);
      valid <= up.in_valid && !up.in_flush;
      if (up.in_valid && !up.in_flush) begin
        rd     <= up.in_rd;
        rd_we  <= up.in_rd_we;
        wb_sel <= up.in_wb_sel;
        alu    <= up.in_alu_result;
        pc     <= up.in_pc;
        ld     <= up.in_load_data;
        f3     <= up.in_funct3;
      end
    end
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RISC-V core, directly upstream of the register file.
- Registers one retiring instruction from the memory stage.
- Selects its result: ALU result, sign/zero-extended load data, or PC+4.
- Drives the register file write port, plus a forwarding copy for the hazard unit and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width
- CNT_W, 64, instret counter width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  memory stage offers an instruction
- in_ready  out  1  stage accepts offered instruction this cycle
- in_flush  in  1  discard the instruction being offered
- wb_stall  in  1  hold the current entry; no write this cycle
- in_rd  in  RA_W  destination register
- in_rd_we  in  1  instruction writes rd
- in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 ALU (LUI/AUIPC path)
- in_alu_result  in  XLEN  ALU result, also the load address
- in_pc  in  XLEN  instruction PC
- in_load_data  in  XLEN  raw aligned memory word
- in_funct3  in  3  load size/sign
- rf_write_en  out  1  register file write enable
- rf_write_reg  out  RA_W  register file write address
- rf_write_data  out  XLEN  register file write data
- fwd_valid  out  1  forwarding copy of rf_write_en
- fwd_rd  out  RA_W  forwarding copy of rf_write_reg
- fwd_data  out  XLEN  forwarding copy of rf_write_data
- exc_valid  out  1  faulting entry retiring this cycle
- exc_cause  out  2  01 misaligned load, 10 illegal load funct3
- instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset, asynchronous, rst_n low:
  - Entry valid cleared; all held fields cleared; instret = 0.
  - Consequently rf_write_en, fwd_valid and exc_valid = 0 and all data/address outputs = 0.
  - Reset mid-stall drops the held entry with no write.
- Handshake:
  - in_ready = !wb_stall.
  - Capture at an edge when in_valid & in_ready & !in_flush.
  - At an edge with in_ready = 1 and no capture (no in_valid, or in_flush = 1), entry valid clears.
  - in_flush only discards the offered instruction; an entry already held always completes.
- Latency:
  - Instruction captured at edge N drives rf_write_* during cycle N..N+1.
  - The register file is written at edge N+1, provided wb_stall is low.
  - Back-to-back captures give one write per cycle.
- Stall:
  - While wb_stall = 1, the entry holds unchanged and rf_write_en is forced 0.
  - The write occurs at the first edge with wb_stall = 0, and the next capture happens at that same edge.
- Write enable:
  - rf_write_en = valid & rd_we & (rd != 0) & !fault & !wb_stall.
  - Writes to x0 are always suppressed.
  - rf_write_reg and rf_write_data are driven from the held entry regardless of enable; they are 0 when invalid.
- Result mux, combinational from held fields:
  - 00/11: alu_result.
  - 10: pc + 4, modulo 2^XLEN, so 0xFFFFFFFC gives 0.
  - 01: load extract, lo = alu_result[1:0]:
    - funct3 000 LB: byte lo, sign-extended.
    - 100 LBU: byte lo, zero-extended.
    - 001 LH: half lo[1], sign-extended; fault if lo[0] = 1.
    - 101 LHU: same as LH, zero-extended.
    - 010 LW: full word; fault if lo != 00.
    - Other funct3 values: fault cause 10.
- Faults:
  - A fault is only evaluated when wb_sel = 01.
  - exc_valid = valid & fault & !wb_stall, held one cycle per entry; exc_cause is valid when exc_valid = 1.
  - A faulting entry never writes and does not increment instret.
- instret:
  - Increments at each edge where valid & !fault & !wb_stall, including rd_we = 0 and rd = x0.
  - Wraps to 0 after all-ones.
- Forwarding outputs equal the rf_write_* outputs cycle-for-cycle, so the hazard unit bypasses the register file's stale read in the write cycle.

Test Plan:
- ALU writeback: rd = 5, we = 1, sel 00, alu = 0x12345678 → next cycle rf_write_en = 1, reg = 5, data = 0x12345678; fwd_* identical; instret = 1.
- Loads with word 0x80FF7F01:
  - LB lo = 2 → 0xFFFFFFFF.
  - LBU lo = 3 → 0x00000080.
  - LH lo = 2 → 0xFFFF80FF.
  - LHU lo = 0 → 0x00007F01.
  - LW lo = 0 → 0x80FF7F01.
- Faults, no write, instret unchanged:
  - LW lo = 2 → exc_valid = 1, cause 01.
  - LH lo = 1 → cause 01.
  - funct3 = 011 → cause 10.
- x0 and JAL:
  - rd = 0, alu = 0xDEAD → rf_write_en = 0, instret +1.
  - sel 10, pc = 0x00000100, rd = 1 → data 0x00000104.
  - pc = 0xFFFFFFFC → 0x00000000.
- Stall/flush:
  - Capture A, then wb_stall = 1 for 3 cycles → rf_write_en = 0 and in_ready = 0 throughout, A held.
  - Release with B offered → A written at release edge, B captured same edge.
  - in_flush with in_valid → next cycle invalid, no write.
- Reset mid-stall: assert rst_n = 0 asynchronously while A is held → all outputs 0 immediately; instret = 0; A never written.
